// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types: the control word carried down the pipeline
// and the MEM-stage access state encoding.
package rv32i_types_pkg;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic       load_regfile;
        logic [4:0] rd;
    } rv32i_control_word;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: issues registered data-memory requests,
// stalls while an access is outstanding, and owns the MEM/WB register.
module mem_stage
    import rv32i_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_valid_in,
    input  rv32i_control_word MEM_ctrl_in,
    input  logic [31:0]       MEM_alu_in,
    input  logic [31:0]       MEM_rs2_in,
    input  logic [31:0]       MEM_u_imm_in,
    input  logic              pipe_stall_in,
    output logic [31:0]       dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [3:0]        dmem_mbe,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              MEM_stall_out,
    output logic              WB_valid_out,
    output rv32i_control_word WB_ctrl_out,
    output logic [31:0]       WB_alu_out,
    output logic [31:0]       WB_mem_out,
    output logic [31:0]       WB_u_imm_out
);

    mem_state_e  state_q;
    logic [31:0] rdata_q;
    logic        memop;
    logic [1:0]  off;
    logic [3:0]  mbe_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_d;

    assign memop = MEM_valid_in & (MEM_ctrl_in.mem_read | MEM_ctrl_in.mem_write);
    assign off   = MEM_alu_in[1:0];

    assign MEM_stall_out = ~rst & (((state_q == ST_IDLE) & memop) | (state_q == ST_BUSY));

    // Store lane placement; unknown store widths behave as sw.
    always_comb begin
        mbe_d   = 4'b1111;
        wdata_d = MEM_rs2_in;
        if (MEM_ctrl_in.mem_write) begin
            case (MEM_ctrl_in.funct3)
                3'b000: begin
                    mbe_d   = 4'b0001 << off;
                    wdata_d = {4{MEM_rs2_in[7:0]}};
                end
                3'b001: begin
                    mbe_d   = 4'b0011 << {off[1], 1'b0};
                    wdata_d = {2{MEM_rs2_in[15:0]}};
                end
                default: begin
                    mbe_d   = 4'b1111;
                    wdata_d = MEM_rs2_in;
                end
            endcase
        end
    end

    always_comb begin
        byte_sel = rdata_q[7:0];
        case (off)
            2'd0: byte_sel = rdata_q[7:0];
            2'd1: byte_sel = rdata_q[15:8];
            2'd2: byte_sel = rdata_q[23:16];
            2'd3: byte_sel = rdata_q[31:24];
            default: byte_sel = rdata_q[7:0];
        endcase
        half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_d   = 32'd0;
        if (MEM_ctrl_in.mem_read) begin
            case (MEM_ctrl_in.funct3)
                3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  load_d = {24'd0, byte_sel};
                3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
                3'b101:  load_d = {16'd0, half_sel};
                default: load_d = rdata_q;
            endcase
        end
    end

    // Access FSM; request outputs are registered and frozen while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_mbe     <= 4'd0;
            dmem_wdata   <= 32'd0;
            dmem_address <= 32'd0;
            rdata_q      <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (memop) begin
                        state_q      <= ST_BUSY;
                        dmem_read    <= MEM_ctrl_in.mem_read;
                        dmem_write   <= MEM_ctrl_in.mem_write;
                        dmem_mbe     <= mbe_d;
                        dmem_wdata   <= wdata_d;
                        dmem_address <= {MEM_alu_in[31:2], 2'b00};
                    end
                end
                ST_BUSY: begin
                    if (dmem_resp) begin
                        state_q    <= ST_DONE;
                        rdata_q    <= dmem_rdata;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!pipe_stall_in) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_valid_out <= 1'b0;
            WB_ctrl_out  <= '0;
            WB_alu_out   <= 32'd0;
            WB_mem_out   <= 32'd0;
            WB_u_imm_out <= 32'd0;
        end else if (!pipe_stall_in) begin
            if (MEM_stall_out) begin
                WB_valid_out <= 1'b0;
            end else begin
                WB_valid_out <= MEM_valid_in;
                WB_ctrl_out  <= MEM_ctrl_in;
                WB_alu_out   <= MEM_alu_in;
                WB_mem_out   <= load_d;
                WB_u_imm_out <= MEM_u_imm_in;
            end
        end
    end

endmodule
